// File: rtl/rc5_pkg.sv
// rc5_pkg: shared FSM state and mode encodings for the RC5 core
package rc5_pkg;
  typedef enum logic [2:0] {IDLE, PRE, ROUND, POST, DONE} state_t;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;
endpackage

// File: rtl/rc5_round_unit.sv
// rc5_round_unit: one combinational RC5 round, encrypt or decrypt
module rc5_round_unit import rc5_pkg::*; #(
  parameter int HW = 16
) (
  input  logic [HW-1:0] a,
  input  logic [HW-1:0] b,
  input  logic [HW-1:0] s_even,
  input  logic [HW-1:0] s_odd,
  input  logic          mode,
  output logic [HW-1:0] a_n,
  output logic [HW-1:0] b_n
);
  localparam int LW = $clog2(HW);
  function automatic logic [HW-1:0] rotl(input logic [HW-1:0] x, input logic [LW-1:0] s);
    logic [2*HW-1:0] t;
    t = {x, x} << s;
    return t[2*HW-1:HW];
  endfunction
  function automatic logic [HW-1:0] rotr(input logic [HW-1:0] x, input logic [LW-1:0] s);
    logic [2*HW-1:0] t;
    t = {x, x} >> s;
    return t[HW-1:0];
  endfunction
  logic [HW-1:0] ea, da, db;
  // decrypt recovers B first because it depends only on the old A
  always_comb begin
    ea = rotl(a ^ b, b[LW-1:0]) + s_even;
    db = rotr(b - s_odd, a[LW-1:0]) ^ a;
    da = rotr(a - s_even, db[LW-1:0]) ^ db;
    a_n = mode == MODE_ENC ? ea : da;
    b_n = mode == MODE_ENC ? rotl(b ^ ea, ea[LW-1:0]) + s_odd : db;
  end
endmodule

// File: rtl/rc5_block_cipher_core.sv
// rc5_block_cipher_core: iterative RC5 enc/dec core, one round per cycle, loadable key table
module rc5_block_cipher_core import rc5_pkg::*; #(
  parameter int W = 32,
  parameter int R = 8,
  localparam int HW = W / 2,
  localparam int T = 2 * R + 2,
  localparam int AW = $clog2(T)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          key_we,
  input  logic [AW-1:0] key_addr,
  input  logic [HW-1:0] key_data,
  output logic          key_busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_mode
);
  state_t state, state_n;
  logic [HW-1:0] a, b, a_n, b_n;
  logic [HW-1:0] s [T];
  logic [AW-1:0] i, ie, io;
  logic mode, last;
  assign ie = {i[AW-2:0], 1'b0};
  assign io = {i[AW-2:0], 1'b1};
  assign last = mode == MODE_ENC ? i == AW'(R) : i == AW'(1);
  assign in_ready = state == IDLE;
  assign key_busy = state != IDLE;
  assign out_valid = state == DONE;
  rc5_round_unit #(.HW(HW)) u_round (
    .a(a), .b(b), .s_even(s[ie]), .s_odd(s[io]), .mode(mode), .a_n(a_n), .b_n(b_n)
  );
  // state register
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  // block sequencing: accept, pre-whiten, R rounds, post-whiten, hold result until taken
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid ? PRE : IDLE;
      PRE:     state_n = ROUND;
      ROUND:   state_n = last ? POST : ROUND;
      POST:    state_n = DONE;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // key table, working halves, round index and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      a <= '0;
      b <= '0;
      i <= '0;
      mode <= MODE_ENC;
      out_data <= '0;
      out_mode <= MODE_ENC;
      for (int k = 0; k < T; k++) s[k] <= '0;
    end else begin
      if (key_we && state == IDLE && 32'(key_addr) < T) s[key_addr] <= key_data;
      case (state)
        IDLE: if (in_valid) begin
          a <= in_data[W-1:HW];
          b <= in_data[HW-1:0];
          mode <= in_mode;
        end
        PRE: begin
          a <= mode == MODE_ENC ? a + s[0] : a;
          b <= mode == MODE_ENC ? b + s[1] : b;
          i <= mode == MODE_ENC ? AW'(1) : AW'(R);
        end
        ROUND: begin
          a <= a_n;
          b <= b_n;
          i <= mode == MODE_ENC ? i + 1'b1 : i - 1'b1;
        end
        POST: begin
          out_data <= mode == MODE_ENC ? {a, b} : {a - s[0], b - s[1]};
          out_mode <= mode;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rc5_block_cipher_core.sv
// tb_rc5_block_cipher_core: directed and random checks of the RC5 core against a loop-based reference
module tb_rc5_block_cipher_core;
  localparam int W = 32, R = 8, HW = W / 2, T = 2 * R + 2, AW = $clog2(T);
  logic clock = 0, reset = 1, key_we = 0, in_valid = 0, in_mode = 0, out_ready = 0;
  logic [AW-1:0] key_addr = '0;
  logic [HW-1:0] key_data = '0;
  logic [W-1:0] in_data = '0;
  logic key_busy, in_ready, out_valid, out_mode;
  logic [W-1:0] out_data;
  logic [HW-1:0] sk [T];
  int tests = 0, fails = 0;

  rc5_block_cipher_core #(.W(W), .R(R)) dut (
    .clock(clock), .reset(reset), .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
    .key_busy(key_busy), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode)
  );

  always #5 clock = ~clock;

  function automatic logic [HW-1:0] rl(input logic [HW-1:0] x, input logic [HW-1:0] r);
    int n;
    n = int'(r % HW);
    return n == 0 ? x : (x << n) | (x >> (HW - n));
  endfunction
  function automatic logic [HW-1:0] rr(input logic [HW-1:0] x, input logic [HW-1:0] r);
    int n;
    n = int'(r % HW);
    return n == 0 ? x : (x >> n) | (x << (HW - n));
  endfunction
  function automatic logic [W-1:0] model(input logic m, input logic [W-1:0] d);
    logic [HW-1:0] x, y;
    x = d[W-1:HW];
    y = d[HW-1:0];
    if (!m) begin
      x = x + sk[0];
      y = y + sk[1];
      for (int r = 1; r <= R; r++) begin
        x = rl(x ^ y, y) + sk[2*r];
        y = rl(y ^ x, x) + sk[2*r+1];
      end
    end else begin
      for (int r = R; r >= 1; r--) begin
        y = rr(y - sk[2*r+1], x) ^ x;
        x = rr(x - sk[2*r], y) ^ y;
      end
      y = y - sk[1];
      x = x - sk[0];
    end
    return {x, y};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic put_key(input int addr, input logic [HW-1:0] d);
    key_we = 1;
    key_addr = AW'(addr);
    key_data = d;
    tick;
    key_we = 0;
    if (addr < T) sk[addr] = d;
  endtask
  task automatic send(input logic m, input logic [W-1:0] d);
    in_valid = 1;
    in_mode = m;
    in_data = d;
    tick;
    in_valid = 0;
  endtask
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 4 * R + 20) begin
      tick;
      n++;
    end
  endtask
  task automatic take;
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask
  task automatic block(input logic m, input logic [W-1:0] d, input string tag, output logic [W-1:0] res);
    logic [W-1:0] e;
    int n;
    e = model(m, d);
    chk({tag, " in_ready"}, W'(in_ready), W'(1));
    send(m, d);
    wait_out(n);
    chk({tag, " latency"}, W'(n), W'(R + 2));
    chk({tag, " data"}, out_data, e);
    chk({tag, " mode"}, W'(out_mode), W'(m));
    res = out_data;
    take;
  endtask

  initial begin
    logic [W-1:0] pt, ct, rt, e, held;
    int n;
    for (int k = 0; k < T; k++) sk[k] = '0;
    tick;
    tick;
    chk("rst in_ready", W'(in_ready), W'(1));
    chk("rst out_valid", W'(out_valid), W'(0));
    chk("rst out_data", out_data, W'(0));
    chk("rst out_mode", W'(out_mode), W'(0));
    chk("rst key_busy", W'(key_busy), W'(0));
    reset = 0;
    tick;
    block(0, W'(0), "zero enc", ct);
    chk("zero enc kat", ct, W'(0));
    block(1, W'(0), "zero dec", ct);
    chk("zero dec kat", ct, W'(0));
    block(0, W'(32'h0001_0000), "zero enc 1", ct);
    for (int k = 0; k < T; k++) put_key(k, HW'($urandom));
    for (int k = 0; k < 60; k++) begin
      pt = W'({$urandom, $urandom});
      block(0, pt, "rnd enc", ct);
      block(1, ct, "rnd dec", rt);
      chk("round trip", rt, pt);
      block(1'($urandom), W'({$urandom, $urandom}), "rnd mix", rt);
    end
    pt = W'({$urandom, $urandom});
    e = model(0, pt);
    send(0, pt);
    wait_out(n);
    held = out_data;
    chk("bp first", held, e);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("bp data", out_data, e);
      chk("bp in_ready", W'(in_ready), W'(0));
      chk("bp out_valid", W'(out_valid), W'(1));
    end
    take;
    chk("bp idle", W'(in_ready), W'(1));
    chk("bp valid low", W'(out_valid), W'(0));
    out_ready = 1;
    pt = W'({$urandom, $urandom});
    e = model(1, pt);
    send(1, pt);
    wait_out(n);
    chk("early ready data", out_data, e);
    tick;
    chk("early ready idle", W'(in_ready), W'(1));
    out_ready = 0;
    pt = W'({$urandom, $urandom});
    e = model(0, pt);
    send(0, pt);
    tick;
    key_we = 1;
    key_addr = AW'(2);
    key_data = ~sk[2];
    chk("busy in round", W'(key_busy), W'(1));
    tick;
    key_we = 0;
    wait_out(n);
    chk("busy write dropped", out_data, e);
    take;
    block(0, pt, "after busy write", ct);
    chk("table kept", ct, e);
    put_key(T, HW'($urandom));
    block(0, pt, "addr T ignored", ct);
    chk("addr T table kept", ct, e);
    key_we = 1;
    key_addr = AW'(0);
    key_data = ~sk[0];
    sk[0] = ~sk[0];
    e = model(0, pt);
    send(0, pt);
    key_we = 0;
    wait_out(n);
    chk("coincident key", out_data, e);
    take;
    send(0, pt);
    tick;
    tick;
    tick;
    reset = 1;
    tick;
    reset = 0;
    for (int k = 0; k < T; k++) sk[k] = '0;
    chk("abort out_valid", W'(out_valid), W'(0));
    chk("abort in_ready", W'(in_ready), W'(1));
    chk("abort key_busy", W'(key_busy), W'(0));
    chk("abort out_data", out_data, W'(0));
    block(0, W'(0), "abort zero enc", ct);
    chk("abort keys zero", ct, W'(0));
    block(0, pt, "abort rnd enc", ct);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
